// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution input scheduler.
`ifndef EXT_ADDR_WIDTH
`define EXT_ADDR_WIDTH 8
`endif

package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Number of ROM reads in one frame: every strip position reads KERNEL pixels per column.
  function automatic int total_issues(input int img_w, input int img_h, input int kernel);
    return (img_h - kernel + 1) * img_w * kernel;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_input_scheduler_if.sv
// ROM read port plus column output bus of the convolution input scheduler.
interface conv_input_scheduler_if #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int KERNEL = 3,
  parameter int ADDR_W = `EXT_ADDR_WIDTH,
  parameter int DATA_W = 32
);
  logic                       enable;
  logic                       i_stall;
  logic [DATA_W-1:0]          data_in;
  logic [ADDR_W-1:0]          ext_rom_addr;
  logic [KERNEL*DATA_W-1:0]   o_col_bus;
  logic                       o_col_valid;
  logic [$clog2(IMG_W)-1:0]   o_col_x;
  logic [$clog2(IMG_H)-1:0]   o_row_y;
  logic                       o_win_valid;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    input  enable, i_stall, data_in,
    output ext_rom_addr, o_col_bus, o_col_valid, o_col_x, o_row_y,
           o_win_valid, o_busy, o_done
  );

  modport slave (
    output enable, i_stall, data_in,
    input  ext_rom_addr, o_col_bus, o_col_valid, o_col_x, o_row_y,
           o_win_valid, o_busy, o_done
  );
endinterface

// File: rtl/conv_sched_addr_gen.sv
// Strip/column/row counters with an incrementally stepped ROM address.
module conv_sched_addr_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int KERNEL = 3,
  parameter int ADDR_W = 8,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int KW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [KW-1:0]     k,
  output logic [XW-1:0]     c,
  output logic [YW-1:0]     r,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  // From the bottom pixel of a column back up to the top pixel of the next one;
  // at the right edge this lands exactly on the first pixel of the next strip.
  localparam logic [ADDR_W-1:0] COL_BACK = ADDR_W'((KERNEL - 1) * IMG_W - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(KERNEL - 1);
  localparam logic [XW-1:0]     C_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     R_LAST   = YW'(IMG_H - KERNEL);

  logic [ADDR_W-1:0] addr_reg;
  logic [KW-1:0]     k_reg;
  logic [XW-1:0]     c_reg;
  logic [YW-1:0]     r_reg;

  assign addr = addr_reg;
  assign k    = k_reg;
  assign c    = c_reg;
  assign r    = r_reg;
  assign last = (k_reg == K_LAST) && (c_reg == C_LAST) && (r_reg == R_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      k_reg    <= '0;
      c_reg    <= '0;
      r_reg    <= '0;
    end else if (advance) begin
      if (last) begin
        addr_reg <= '0;
        k_reg    <= '0;
        c_reg    <= '0;
        r_reg    <= '0;
      end else if (k_reg != K_LAST) begin
        k_reg    <= k_reg + KW'(1);
        addr_reg <= addr_reg + ROW_STEP;
      end else begin
        k_reg    <= '0;
        addr_reg <= addr_reg - COL_BACK;
        if (c_reg == C_LAST) begin
          c_reg <= '0;
          r_reg <= r_reg + YW'(1);
        end else begin
          c_reg <= c_reg + XW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/conv_input_scheduler.sv
// Convolution input scheduler: drives the pixel ROM in KERNEL-row strips and
// emits one KERNEL-pixel column per strip position with window qualification.
module conv_input_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int KERNEL  = 3,
  parameter int ADDR_W  = `EXT_ADDR_WIDTH,
  parameter int ROM_LAT = 0,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst_n,
  conv_input_scheduler_if.master bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int KW = cnt_width(KERNEL);
  localparam logic [KW-1:0] K_LAST = KW'(KERNEL - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(KERNEL - 1);

  sched_state_t             state_reg;
  logic                     enable_prev_reg;
  logic [KERNEL*DATA_W-1:0] col_bus_reg;
  logic                     col_valid_reg;
  logic [XW-1:0]            col_x_reg;
  logic [YW-1:0]            row_y_reg;
  logic                     win_valid_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic                     issue;
  logic [ADDR_W-1:0]        gen_addr;
  logic [KW-1:0]            gen_k;
  logic [XW-1:0]            gen_c;
  logic [YW-1:0]            gen_r;
  logic                     gen_last;

  logic                     cap_valid;
  logic [KW-1:0]            cap_k;
  logic [XW-1:0]            cap_c;
  logic [YW-1:0]            cap_r;
  logic                     inflight;
  logic [KERNEL*DATA_W-1:0] col_next;

  assign issue = (state_reg == FETCH) && !bus.i_stall;

  conv_sched_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .ADDR_W(ADDR_W),
    .XW(XW), .YW(YW), .KW(KW)
  ) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .advance(issue),
    .addr(gen_addr), .k(gen_k), .c(gen_c), .r(gen_r), .last(gen_last)
  );

  // The position tag travels alongside the read so it lines up with data_in.
  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign cap_valid = issue;
      assign cap_k     = gen_k;
      assign cap_c     = gen_c;
      assign cap_r     = gen_r;
      assign inflight  = 1'b0;
    end else begin : g_lat1
      logic          tag_valid_reg;
      logic [KW-1:0] tag_k_reg;
      logic [XW-1:0] tag_c_reg;
      logic [YW-1:0] tag_r_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid_reg <= 1'b0;
          tag_k_reg     <= '0;
          tag_c_reg     <= '0;
          tag_r_reg     <= '0;
        end else begin
          tag_valid_reg <= issue;
          tag_k_reg     <= gen_k;
          tag_c_reg     <= gen_c;
          tag_r_reg     <= gen_r;
        end
      end
      assign cap_valid = tag_valid_reg;
      assign cap_k     = tag_k_reg;
      assign cap_c     = tag_c_reg;
      assign cap_r     = tag_r_reg;
      assign inflight  = tag_valid_reg;
    end
  endgenerate

  // Upper pixels wait in slots; the bottom pixel goes straight from data_in into the bus.
  genvar gi;
  generate
    for (gi = 0; gi < KERNEL - 1; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot_reg <= '0;
        else if (cap_valid && (cap_k == KW'(gi)))
          slot_reg <= bus.data_in;
      end
      assign col_next[(KERNEL-1-gi)*DATA_W +: DATA_W] = slot_reg;
    end
  endgenerate
  assign col_next[DATA_W-1:0] = bus.data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      enable_prev_reg <= 1'b0;
      col_bus_reg     <= '0;
      col_valid_reg   <= 1'b0;
      col_x_reg       <= '0;
      row_y_reg       <= '0;
      win_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      enable_prev_reg <= bus.enable;
      col_valid_reg   <= 1'b0;
      win_valid_reg   <= 1'b0;
      done_reg        <= 1'b0;
      if (cap_valid && (cap_k == K_LAST)) begin
        col_bus_reg   <= col_next;
        col_x_reg     <= cap_c;
        row_y_reg     <= cap_r;
        col_valid_reg <= 1'b1;
        win_valid_reg <= (cap_c >= X_WIN);
      end
      case (state_reg)
        IDLE: if (bus.enable && !enable_prev_reg) begin
          state_reg <= FETCH;
          busy_reg  <= 1'b1;
        end
        FETCH: if (issue && gen_last) state_reg <= DRAIN;
        DRAIN: if (!inflight) begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ext_rom_addr = gen_addr;
  assign bus.o_col_bus    = col_bus_reg;
  assign bus.o_col_valid  = col_valid_reg;
  assign bus.o_col_x      = col_x_reg;
  assign bus.o_row_y      = row_y_reg;
  assign bus.o_win_valid  = win_valid_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_done       = done_reg;
endmodule

// File: tb/tb_conv_input_scheduler.sv
// Runs a ROM_LAT=0 and a ROM_LAT=1 scheduler side by side from shared stimulus and
// checks every cycle against a frame-level model built from the scan order.
module tb_conv_input_scheduler;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int KERNEL = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NISS   = (IMG_H - KERNEL + 1) * IMG_W * KERNEL;
  localparam int NCOL   = NISS / KERNEL;
  localparam int BW     = KERNEL * DATA_W;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic stall;
  always #5 clk = ~clk;

  conv_input_scheduler_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL),
                            .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  conv_input_scheduler_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL),
                            .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  conv_input_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .ADDR_W(ADDR_W),
                         .ROM_LAT(0), .DATA_W(DATA_W))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  conv_input_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .ADDR_W(ADDR_W),
                         .ROM_LAT(1), .DATA_W(DATA_W))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [DATA_W-1:0] rom [IMG_W*IMG_H];
  logic [DATA_W-1:0] rom1_q;
  assign bus0.data_in = rom[bus0.ext_rom_addr];
  always @(posedge clk) rom1_q <= rom[bus1.ext_rom_addr];
  assign bus1.data_in = rom1_q;
  assign bus0.enable  = enable;
  assign bus1.enable  = enable;
  assign bus0.i_stall = stall;
  assign bus1.i_stall = stall;

  // Reference model state
  int addr_q [NISS];
  int iss_cyc[NISS];
  int cyc, issued;
  int nxt[2], done_at[2], cnt_valid[2], cnt_done[2];
  bit m_fetch, en_prev, directed_armed;
  bit run[2];
  int stall_left, stall_pct;
  bit en_drive;
  int n_assert, n_fail;

  task automatic chk(input string tag, input int d, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic sample(input int d, output logic [ADDR_W-1:0] a, output logic [BW-1:0] b,
                        output logic v, output logic w, output logic bz, output logic dn,
                        output logic [XW-1:0] x, output logic [YW-1:0] y);
    if (d == 0) begin
      a = bus0.ext_rom_addr; b = bus0.o_col_bus; v = bus0.o_col_valid; w = bus0.o_win_valid;
      bz = bus0.o_busy; dn = bus0.o_done; x = bus0.o_col_x; y = bus0.o_row_y;
    end else begin
      a = bus1.ext_rom_addr; b = bus1.o_col_bus; v = bus1.o_col_valid; w = bus1.o_win_valid;
      bz = bus1.o_busy; dn = bus1.o_done; x = bus1.o_col_x; y = bus1.o_row_y;
    end
  endtask

  task automatic check_zero(input int d);
    logic [ADDR_W-1:0] a; logic [BW-1:0] b; logic v, w, bz, dn; logic [XW-1:0] x; logic [YW-1:0] y;
    sample(d, a, b, v, w, bz, dn, x, y);
    chk("rst_addr", d, BW'(a), '0);
    chk("rst_bus", d, b, '0);
    chk("rst_flags", d, BW'({v, w, bz, dn}), '0);
    chk("rst_xy", d, BW'({x, y}), '0);
  endtask

  task automatic check_cycle(input int d);
    logic [ADDR_W-1:0] a; logic [BW-1:0] b; logic v, w, bz, dn; logic [XW-1:0] x; logic [YW-1:0] y;
    logic [BW-1:0] exp_bus;
    int j, exp_addr;
    logic exp_v, exp_w, exp_busy, exp_done;
    sample(d, a, b, v, w, bz, dn, x, y);
    exp_addr = m_fetch ? addr_q[issued] : 0;
    chk("ext_rom_addr", d, BW'(a), BW'(exp_addr));
    j = nxt[d];
    exp_v = (j < NCOL) && (issued > j*KERNEL + KERNEL - 1) &&
            (iss_cyc[j*KERNEL + KERNEL - 1] + d + 1 == cyc);
    exp_w = exp_v && ((j % IMG_W) >= KERNEL - 1);
    chk("o_col_valid", d, BW'(v), BW'(exp_v));
    chk("o_win_valid", d, BW'(w), BW'(exp_w));
    if (v) cnt_valid[d]++;
    if (dn) cnt_done[d]++;
    if (exp_v) begin
      exp_bus = '0;
      for (int k = 0; k < KERNEL; k++)
        exp_bus[(KERNEL-1-k)*DATA_W +: DATA_W] = rom[addr_q[j*KERNEL + k]];
      chk("o_col_bus", d, b, exp_bus);
      chk("o_col_x", d, BW'(x), BW'(j % IMG_W));
      chk("o_row_y", d, BW'(y), BW'(j / IMG_W));
      $display("lat=%0d cyc=%0d column x=%0d y=%0d bus=%h", d, cyc, x, y, b);
      nxt[d]++;
      if (nxt[d] == NCOL) done_at[d] = cyc + 1;
    end
    exp_busy = run[d] && (done_at[d] < 0 || cyc < done_at[d]);
    exp_done = run[d] && (done_at[d] == cyc);
    chk("o_busy", d, BW'(bz), BW'(exp_busy));
    chk("o_done", d, BW'(dn), BW'(exp_done));
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
    if (stall_left > 0) begin
      stall = 1'b1; stall_left--;
    end else if (directed_armed && m_fetch && issued == 5) begin
      directed_armed = 1'b0; stall = 1'b1; stall_left = 4;
    end else begin
      stall = ($urandom_range(0, 99) < stall_pct);
    end
    enable = en_drive;
    if (m_fetch && !stall) begin
      iss_cyc[issued] = cyc;
      issued++;
      if (issued == NISS) m_fetch = 1'b0;
    end else if (!m_fetch && !run[0] && !run[1] && enable && !en_prev) begin
      m_fetch = 1'b1; issued = 0;
      for (int d = 0; d < 2; d++) begin
        nxt[d] = 0; done_at[d] = -1; run[d] = 1'b1; cnt_valid[d] = 0; cnt_done[d] = 0;
      end
    end
    for (int d = 0; d < 2; d++)
      if (run[d] && done_at[d] >= 0 && cyc >= done_at[d]) run[d] = 1'b0;
    en_prev = enable;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_frame();
    int n = 0;
    step();
    while ((m_fetch || run[0] || run[1]) && n < 8000) begin
      step(); n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk("col_count", d, BW'(cnt_valid[d]), BW'(NCOL));
      chk("done_count", d, BW'(cnt_done[d]), BW'(1));
    end
  endtask

  initial begin
    int idx;
    n_assert = 0; n_fail = 0; cyc = 0; issued = 0; m_fetch = 0; en_prev = 0;
    stall_left = 0; stall_pct = 0; en_drive = 0; directed_armed = 0;
    for (int d = 0; d < 2; d++) begin
      nxt[d] = 0; done_at[d] = -1; run[d] = 0; cnt_valid[d] = 0; cnt_done[d] = 0;
    end
    for (int i = 0; i < IMG_W*IMG_H; i++) rom[i] = ($urandom() & 32'hFFFF_FF00) | i;
    idx = 0;
    for (int r = 0; r <= IMG_H - KERNEL; r++)
      for (int c = 0; c < IMG_W; c++)
        for (int k = 0; k < KERNEL; k++)
          addr_q[idx++] = (r + k) * IMG_W + c;

    rst_n = 1'b0; enable = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero(0); check_zero(1);
    rst_n = 1'b1;
    repeat (4) step();

    // Frame A: directed 5-cycle stall after address 17, random stalls elsewhere
    en_drive = 1'b1; directed_armed = 1'b1; stall_pct = 15;
    run_frame();
    // Enable held high: no restart
    repeat (30) step();

    // Frame B: reset at the 100th issue
    en_drive = 1'b0; repeat (3) step();
    en_drive = 1'b1; stall_pct = 0;
    step();
    for (int n = 0; n < 2000 && issued < 100; n++) step();
    #2;
    rst_n = 1'b0; enable = 1'b0; en_drive = 1'b0;
    #1;
    check_zero(0); check_zero(1);
    m_fetch = 1'b0; issued = 0; en_prev = 1'b0; stall_left = 0;
    for (int d = 0; d < 2; d++) begin run[d] = 1'b0; done_at[d] = -1; nxt[d] = 0; end
    @(posedge clk); cyc++;
    #2;
    check_zero(0); check_zero(1);
    rst_n = 1'b1;
    repeat (5) step();

    // Frame C: restart from address 0 with heavier random stalls
    en_drive = 1'b1; stall_pct = 25;
    run_frame();
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_input_scheduler.md
Name: conv_input_scheduler

Overview:
Sequences external pixel-ROM reads for the convolution layer. It scans an IMG_W x IMG_H row-major image, which is one 32-bit word per pixel, in vertical strips KERNEL rows tall. Each strip is read column by column, and each column of KERNEL pixels goes to the kernel datapath with position and window-valid flags. It owns ext_rom_addr, so the conv layer no longer free-runs the ROM address.

Parameters:
IMG_W, 16, image width in pixels
IMG_H, 16, image height in pixels
KERNEL, 3, kernel height/width, which is also the number of pixels per emitted column
ADDR_W, `EXT_ADDR_WIDTH (8), ROM address width; IMG_W*IMG_H must be <= 2**ADDR_W
ROM_LAT, 0, ROM read latency in cycles; only 0 (distributed ROM, combinational spo) or 1 (registered block ROM) is legal
DATA_W, 32, pixel width

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  start request; a frame starts on a 0->1 edge of enable while in IDLE
i_stall  in  1  downstream back-pressure; while high, no new ROM address is issued
data_in  in  DATA_W  ROM read data, valid ROM_LAT cycles after ext_rom_addr
ext_rom_addr  out  ADDR_W  ROM read address
o_col_bus  out  KERNEL*DATA_W  one pixel column; the top row (k=0) is in the MSB slice
o_col_valid  out  1  one-cycle strobe: o_col_bus holds a complete column
o_col_x  out  $clog2(IMG_W)  column index of the emitted column
o_row_y  out  $clog2(IMG_H)  strip top-row index of the emitted column
o_win_valid  out  1  qualifies o_col_valid; high when o_col_x >= KERNEL-1, meaning a full KxK window is now available
o_busy  out  1  high from the frame start until o_done
o_done  out  1  one-cycle strobe after the last column of the frame is emitted

Behaviour:
- Reset (async assert, sync release): state=IDLE, and every counter, output and bus is 0.
- Issue order: for r in 0..IMG_H-KERNEL, for c in 0..IMG_W-1, for k in 0..KERNEL-1, issue addr = (r+k)*IMG_W + c. Compute the address incrementally (add IMG_W, then step back to the next column); do not multiply.
- Total issues per frame = (IMG_H-KERNEL+1)*IMG_W*KERNEL, which is 672 at the defaults.
- States:
  - IDLE: ext_rom_addr=0. An enable rising edge (previous enable sample 0, current 1) moves to FETCH. Enable held high after a frame does not restart it.
  - FETCH: issue one address per cycle when i_stall=0. i_stall=1 holds all counters, and ext_rom_addr holds its value. After the final issue (r=IMG_H-KERNEL, c=IMG_W-1, k=KERNEL-1) go to DRAIN.
  - DRAIN: wait until the in-flight read has been captured (0 cycles if ROM_LAT=0, 1 cycle if ROM_LAT=1). Emit the last column, then go to DONE.
  - DONE: o_done=1 for one cycle, o_busy drops, return to IDLE.
- Capture: a ROM_LAT-deep valid/k/c/r tag pipeline accompanies each issue.
  - When the tagged data returns, write it into column slot k.
  - When k=KERNEL-1, register o_col_bus, o_col_x and o_row_y, and pulse o_col_valid on the next cycle.
  - Latency from the issue of a column's last pixel to o_col_valid is ROM_LAT+1 cycles.
- Stall: reads already issued (at most ROM_LAT) still complete and are emitted; stall never drops or duplicates a pixel.
- enable falling mid-frame has no effect; a frame runs to completion.
- o_win_valid = o_col_valid && (o_col_x >= KERNEL-1).
- Wrap: column counter IMG_W-1 -> 0 with row +1. Row counter reaching IMG_H-KERNEL with column IMG_W-1 ends the frame. No address exceeds IMG_W*IMG_H-1.
- Reset mid-frame: immediate return to IDLE with everything cleared; no o_done.
- Simultaneous i_stall and the final issue: the final issue does not happen until i_stall falls.

Decomposition:
- Package conv_sched_pkg: state enum (IDLE, FETCH, DRAIN, DONE) and a localparam function for the total issue count.
- One sub-module, conv_sched_addr_gen: the r/c/k counters, incremental address, last-issue flag, and stall hold.
- The top level holds the FSM, the tag pipeline, the column assembly and the outputs.

Test Plan:
- Defaults, ROM_LAT=0, ROM loaded with data=addr: reset then enable edge -> ext_rom_addr sequence 0,16,32,1,17,33,2,...; first o_col_bus={0,16,32} with o_col_x=0 and o_win_valid=0; o_win_valid first goes high at o_col_x=2 (column {2,18,34}).
- Strip boundary: after column 15 of row 0 (addresses 15,31,47), the next addresses are 16,32,48, and o_row_y becomes 1 on that column.
- Frame end: last address 255 (r=13, c=15, k=2); last column {223,239,255}; exactly 672 issues and 224 o_col_valid strobes; o_done high for one cycle; o_busy falls with it; enable held high causes no restart.
- Stall: i_stall=1 for 5 cycles after address 17 -> ext_rom_addr holds at the next address (33) for 5 cycles; the column output is still exactly {1,17,33}; repeat with ROM_LAT=1 and check that the in-flight word is not lost.
- Reset mid-frame at the 100th issue -> all outputs 0 next edge, state IDLE, no o_done; a new enable edge restarts from address 0.
- ROM_LAT=1: same sequences as above, with every o_col_valid shifted one cycle later relative to ROM_LAT=0.
